// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the asynchronous FIFO write/read domain blocks.
package fifo_pkg;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;

  // Ceiling log2, usable in constant (parameter) expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer for the FIFO read side: registered storage, wrap-around
// pointers and an occupancy counter, head word presented combinationally.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = fifo_pkg::DATASIZE,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        rclk,
  input  logic                        r_rst,
  input  logic                        wr_en,
  input  logic [DATASIZE-1:0]         wr_data,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [DATASIZE-1:0]         rd_data,
  output logic [clog2(BUF_DEPTH):0]   occupancy
);

  localparam int PW = clog2(BUF_DEPTH);
  localparam int OW = PW + 1;

  logic [DATASIZE-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [OW-1:0]       r_occ;
  logic                w_rd;

  assign rd_valid  = (r_occ != '0);
  assign w_rd      = rd_en & rd_valid;
  assign rd_data   = r_mem[r_rd_ptr];
  assign occupancy = r_occ;

  // BUF_DEPTH is a power of two, so pointers wrap naturally at PW bits.
  always_ff @(posedge rclk) begin
    if (r_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({wr_en, w_rd})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (wr_en && !r_rst) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side consumer of the async FIFO: pops the RAM ahead of demand and presents
// a first-word-fall-through stream, sustaining one word per rclk.
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int DATASIZE  = fifo_pkg::DATASIZE,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      rclk,
  input  logic                      r_rst,
  input  logic                      empty,
  output logic                      rinc,
  input  logic [DATASIZE-1:0]       rdata,
  output logic                      m_valid,
  output logic [DATASIZE-1:0]       m_data,
  input  logic                      m_ready,
  output logic [clog2(BUF_DEPTH):0] occupancy
);

  localparam int CW = clog2(BUF_DEPTH) + 2;

  // Handshake: a word transfers on any rclk edge where m_valid & m_ready; while
  // m_valid & ~m_ready, m_valid and m_data hold; m_ready is ignored when m_valid=0.
  logic          r_infl;
  logic          w_deq;
  logic          w_pop;
  logic [CW-1:0] w_credit;

  assign w_deq = m_valid & m_ready;

  // Words committed to the buffer after this edge; one extra bit so it never wraps.
  assign w_credit = CW'(occupancy) + CW'(r_infl) - CW'(w_deq);
  assign rinc     = ~r_rst & ~empty & (w_credit < CW'(BUF_DEPTH));
  assign w_pop    = rinc & ~empty;

  // RAM read latency is one cycle, so the popped word is captured one edge later.
  always_ff @(posedge rclk) begin
    if (r_rst) r_infl <= 1'b0;
    else       r_infl <= w_pop;
  end

  fifo_rd_skid_buf #(
    .DATASIZE  (DATASIZE),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .rclk      (rclk),
    .r_rst     (r_rst),
    .wr_en     (r_infl),
    .wr_data   (rdata),
    .rd_en     (w_deq),
    .rd_valid  (m_valid),
    .rd_data   (m_data),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Bench for fifo_rd_prefetch: queue-based FIFO source, queue model of the output
// buffer checked every cycle, and directed scenarios with literal expectations.
module tb_fifo_rd_prefetch;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int BD = 2;
  localparam int OW = clog2(BD) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic          rclk = 1'b0;
  logic          r_rst;
  logic          empty;
  logic          rinc;
  logic [W-1:0]  rdata;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready;
  logic [OW-1:0] occupancy;

  always #5 rclk = ~rclk;

  fifo_rd_prefetch #(.DATASIZE(W), .BUF_DEPTH(BD)) dut (
    .rclk      (rclk),
    .r_rst     (r_rst),
    .empty     (empty),
    .rinc      (rinc),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .occupancy (occupancy)
  );

  // ---------------- source, model, scoreboard ----------------
  logic [W-1:0] src_q[$];   // words still in the FIFO RAM
  logic [W-1:0] exp_q[$];   // delivery order expected at m_data
  logic [W-1:0] mbuf[$];    // model of words held in the output buffer
  bit           m_infl;
  logic [W-1:0] m_infl_word;

  int n_checks = 0;
  int n_pass   = 0;

  logic         s_rinc;
  logic         s_valid;
  logic [W-1:0] s_data;
  int           s_occ;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic load(input logic [W-1:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      src_q.push_back(first + W'(i));
      exp_q.push_back(first + W'(i));
    end
  endtask

  // One rclk cycle: drive empty, compare at negedge, advance model at posedge,
  // then present RAM read data for any pop that happened on that edge.
  task automatic cycle();
    bit pop;
    bit mdeq;
    bit exp_rinc;
    int credit;
    empty = (src_q.size() == 0);
    @(negedge rclk);
    s_rinc  = rinc;
    s_valid = m_valid;
    s_data  = m_data;
    s_occ   = int'(occupancy);
    mdeq     = (mbuf.size() != 0) && m_ready;
    credit   = mbuf.size() + int'(m_infl) - int'(mdeq);
    exp_rinc = !r_rst && !empty && (credit < BD);
    check("rinc", s_rinc, exp_rinc);
    check("m_valid", s_valid, mbuf.size() != 0);
    check("occupancy", s_occ, mbuf.size());
    check("rinc_while_empty", s_rinc & empty, 0);
    if (mbuf.size() != 0) check("m_data", s_data, mbuf[0]);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra: got %0h expected no word (t=%0t)", s_data, $time);
      end else begin
        check("sb_order", s_data, exp_q.pop_front());
      end
    end
    pop = s_rinc & ~empty;
    @(posedge rclk);
    if (r_rst) begin
      mbuf.delete();
      m_infl = 1'b0;
    end else begin
      if (mdeq) void'(mbuf.pop_front());
      if (m_infl) mbuf.push_back(m_infl_word);
      m_infl = pop;
      if (pop) m_infl_word = src_q[0];
    end
    #1;
    if (pop) rdata = src_q.pop_front();
    else     rdata = 8'hEE;
  endtask

  // Run until every loaded word is delivered; alt selects 1010... on m_ready.
  task automatic run_until_idle(input int limit, input bit alt);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mbuf.size() != 0 || m_infl) && k < limit) begin
      m_ready = alt ? (k % 2 == 0) : 1'b1;
      cycle();
      k++;
    end
    check("drained", exp_q.size() + mbuf.size() + int'(m_infl), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    r_rst   = 1'b1;
    m_ready = 1'b0;
    rdata   = 8'hEE;
    empty   = 1'b1;
    m_infl  = 1'b0;
    m_infl_word = '0;

    // Reset drain: FIFO non-empty while reset is held.
    load(8'h3C, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_rinc", s_rinc, 0);
      check("rst_valid", s_valid, 0);
      check("rst_occ", s_occ, 0);
    end
    r_rst = 1'b0;
    cycle();
    check("rst_release_rinc", s_rinc, 1);
    run_until_idle(20, 1'b0);

    // Single word A5: rinc, 2-cycle latency to m_valid, gone after accept.
    for (int i = 0; i < 3; i++) cycle();
    m_ready = 1'b1;
    load(8'hA5, 1);
    cycle();
    check("single_rinc", s_rinc, 1);
    cycle();
    check("single_not_yet_valid", s_valid, 0);
    cycle();
    check("single_valid", s_valid, 1);
    check("single_data", s_data, 8'hA5);
    cycle();
    check("single_gone", s_valid, 0);

    // Streaming 0x00..0x0F with no bubbles.
    load(8'h00, 16);
    cycle();
    cycle();
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("stream_valid", s_valid, 1);
      check("stream_data", s_data, i);
    end
    cycle();
    check("stream_end", s_valid, 0);
    run_until_idle(10, 1'b0);

    // Backpressure: m_ready low for cycles 5..14, buffer fills to 2 holding 0x23.
    load(8'h20, 16);
    for (int k = 0; k < 15; k++) begin
      m_ready = !(k >= 5 && k <= 14);
      cycle();
      if (k >= 7) begin
        check("bp_occ_full", s_occ, 2);
        check("bp_rinc_off", s_rinc, 0);
        check("bp_data_hold", s_data, 8'h23);
      end
    end
    run_until_idle(60, 1'b0);

    // Alternating m_ready over 20 words.
    load(8'h40, 20);
    run_until_idle(120, 1'b1);

    // Reset mid-stream with one word buffered and one in flight.
    m_ready = 1'b0;
    load(8'h60, 16);
    cycle();
    cycle();
    r_rst = 1'b1;
    cycle();
    check("midrst_pre_occ", s_occ, 1);
    check("midrst_pre_valid", s_valid, 1);
    src_q.delete();
    exp_q.delete();
    r_rst = 1'b0;
    m_ready = 1'b1;
    cycle();
    check("midrst_valid", s_valid, 0);
    check("midrst_occ", s_occ, 0);
    cycle();
    check("midrst_no_capture", s_occ, 0);
    check("midrst_no_rinc", s_rinc, 0);

    // Recovery after reset.
    load(8'h77, 3);
    run_until_idle(20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
